// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM output peripheral.
// The default CLK_DIV value is also documented in the SPI register map.
package pwm_pkg;

  localparam int PWM_CNT_W           = 8;
  localparam int NUM_PINS            = 16;
  localparam int PWM_CLK_DIV_DEFAULT = 13;
  localparam int PWM_PRESC_W_DEFAULT = 16;

  localparam logic [PWM_CNT_W-1:0] PWM_DUTY_FULL = 8'hFF;

  typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;
  typedef logic [NUM_PINS-1:0]  pwm_pins_t;

  // Full-scale duty is forced high so 0xFF has no one-count dropout at 255.
  function automatic logic pwm_compare(input pwm_cnt_t cnt, input pwm_cnt_t duty_val);
    return (duty_val == PWM_DUTY_FULL) ? 1'b1 : (cnt < duty_val);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus free-running 8-bit PWM counter; shareable by further PWM channels.
// o_wrap marks the cycle on which the counter steps 255 -> 0.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = PWM_CLK_DIV_DEFAULT,
  parameter int PRESC_W = PWM_PRESC_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 o_tick,
  output logic [PWM_CNT_W-1:0] o_pwm_cnt,
  output logic                 o_wrap
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

  logic [PRESC_W-1:0]   r_presc;
  logic [PWM_CNT_W-1:0] r_pwm_cnt;
  logic                 w_tick;

  // With CLK_DIV=1 PRESC_LAST is 0, so the prescaler sits at 0 and ticks every cycle.
  assign w_tick = (r_presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= '0;
    end else if (w_tick) begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end
  end

  assign o_tick    = w_tick;
  assign o_pwm_cnt = r_pwm_cnt;
  assign o_wrap    = w_tick && (r_pwm_cnt == {PWM_CNT_W{1'b1}});

endmodule

// File: rtl/pwm_peripheral.sv
// Sixteen registered output pins, each off, static high or driven by one shared PWM
// waveform whose duty is double-buffered and only updated at the period boundary.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = PWM_CLK_DIV_DEFAULT,
  parameter int PRESC_W = PWM_PRESC_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PINS-1:0]  en_out,
  input  logic [NUM_PINS-1:0]  en_pwm,
  input  logic [PWM_CNT_W-1:0] duty,
  output logic [NUM_PINS-1:0]  pwm_out,
  output logic                 period_start
);

  logic                 w_tick;
  logic                 w_wrap;
  logic [PWM_CNT_W-1:0] w_pwm_cnt;
  logic                 w_pwm_sig;
  pwm_pins_t            w_next_out;

  pwm_cnt_t             r_duty_active;
  pwm_pins_t            r_pwm_out;

  pwm_timebase #(
    .CLK_DIV (CLK_DIV),
    .PRESC_W (PRESC_W)
  ) u_timebase (
    .clk       (clk),
    .rst_n     (rst_n),
    .o_tick    (w_tick),
    .o_pwm_cnt (w_pwm_cnt),
    .o_wrap    (w_wrap)
  );

  // duty is sampled only on the wrap cycle; mid-period writes wait for the next boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty_active <= '0;
    end else if (w_tick && w_wrap) begin
      r_duty_active <= duty;
    end
  end

  assign w_pwm_sig = pwm_compare(w_pwm_cnt, r_duty_active);

  always_comb begin
    w_next_out = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      w_next_out[i] = en_out[i] ? (en_pwm[i] ? w_pwm_sig : 1'b1) : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_out <= '0;
    end else begin
      r_pwm_out <= w_next_out;
    end
  end

  assign pwm_out      = r_pwm_out;
  assign period_start = w_wrap;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: arithmetic model of the timebase checked every cycle,
// plus directed scenarios with hand-computed counts and pin values.
module tb_pwm_peripheral;

  localparam int CLK_DIV = 13;
  localparam int PERIOD  = 256 * CLK_DIV;

  logic        clk;
  logic        rst_n;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;
  logic [15:0] pwm_out;
  logic        period_start;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: edges since reset release, active duty, expected registered pins
  int          m_n;
  logic [7:0]  m_da;
  logic [15:0] m_out;
  logic        m_sig;

  pwm_peripheral #(.CLK_DIV(CLK_DIV), .PRESC_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_out       (en_out),
    .en_pwm       (en_pwm),
    .duty         (duty),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: counter value is simply (edges / CLK_DIV) mod 256.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n   = 0;
      m_da  = 8'h00;
      m_out = 16'h0000;
    end else begin
      m_sig = (m_da == 8'hFF) || (((m_n / CLK_DIV) % 256) < m_da);
      for (int i = 0; i < 16; i++) m_out[i] = en_out[i] && (!en_pwm[i] || m_sig);
      if ((m_n % PERIOD) == PERIOD - 1) m_da = duty;
      m_n = m_n + 1;
    end
  end

  // compare process
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_pwm_out", {16'h0, pwm_out}, 32'h0);
      chk("rst_period_start", {31'h0, period_start}, 32'h0);
    end else begin
      chk("model_pwm_out", {16'h0, pwm_out}, {16'h0, m_out});
      chk("model_period_start", {31'h0, period_start},
          {31'h0, ((m_n % PERIOD) == PERIOD - 1)});
    end
  end

  // Wait (bounded) for a period_start negedge, then step to the first sample of the new period.
  task automatic wait_ps();
    int k;
    for (k = 0; k < PERIOD + 100; k++) begin
      @(negedge clk);
      if (period_start) break;
    end
    chk("wait_ps_timeout", {31'h0, (k >= PERIOD + 100)}, 32'h0);
    @(negedge clk);
  endtask

  // Samples j=2..PERIOD+1 cover counts 0..255 of one period; duty is rewritten at j==chg_j.
  task automatic measure(input logic [7:0] chg_val, input int chg_j,
                         output int highs, output int ps_at);
    highs = 0;
    ps_at = 0;
    for (int j = 2; j <= PERIOD + 1; j++) begin
      @(negedge clk);
      if (pwm_out[0]) highs++;
      if (period_start && ps_at == 0) ps_at = j;
      if (j == chg_j) duty = chg_val;
    end
  endtask

  initial begin
    int hi, ps_at, k;
    rst_n  = 1'b0;
    en_out = 16'hFFFF;
    en_pwm = 16'h0000;
    duty   = 8'h80;

    // reset state and first post-reset edge
    repeat (3) @(negedge clk);
    chk("t1_in_reset", {16'h0, pwm_out}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_first_edge", {16'h0, pwm_out}, 32'h0000FFFF);

    // 50% duty on bit 0
    en_out = 16'h0001;
    en_pwm = 16'h0001;
    wait_ps();
    measure(8'h00, 3000, hi, ps_at);
    chk("t2_high_clks", hi, 1664);
    chk("t2_low_clks", PERIOD - hi, 1664);
    chk("t2_period", ps_at, 3328);

    // duty sweep 0x00 / 0x01 / 0xFF
    measure(8'h01, 3000, hi, ps_at);
    chk("t3_duty00_high", hi, 0);
    measure(8'hFF, 3000, hi, ps_at);
    chk("t3_duty01_high", hi, 13);
    measure(8'hFF, 3000, hi, ps_at);
    chk("t3_dutyFF_p1", hi, 3328);
    measure(8'hFF, 3000, hi, ps_at);
    chk("t3_dutyFF_p2", hi, 3328);
    measure(8'h40, 3000, hi, ps_at);
    chk("t3_dutyFF_p3", hi, 3328);

    // duty rewritten at count 0x20 only applies from the next period
    measure(8'hC0, 418, hi, ps_at);
    chk("t4_old_duty_kept", hi, 832);
    chk("t4_period", ps_at, 3328);
    en_out = 16'hA5A5;
    en_pwm = 16'h00FF;
    measure(8'h40, 3000, hi, ps_at);
    chk("t4_new_duty", hi, 2496);

    // mixed static / PWM pins, then en_pwm dropped mid-period
    for (int j = 2; j <= PERIOD + 1; j++) begin
      @(negedge clk);
      if (j == 100)  chk("t5_pwm_high", {16'h0, pwm_out}, 32'h0000A5A5);
      if (j == 2000) chk("t5_pwm_low", {16'h0, pwm_out}, 32'h0000A500);
      if (j == 2500) en_pwm = 16'h0000;
      if (j == 2600) chk("t5_static_now", {16'h0, pwm_out}, 32'h0000A5A5);
    end

    // asynchronous reset at pwm_cnt=0x77, then full-length first period
    repeat (8'h77 * CLK_DIV) @(negedge clk);
    chk("t6_before_reset", {16'h0, pwm_out}, 32'h0000A5A5);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_async_out", {16'h0, pwm_out}, 32'h0);
    chk("t6_async_ps", {31'h0, period_start}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (k = 1; k <= PERIOD + 100; k++) begin
      @(negedge clk);
      if (period_start) break;
    end
    // period_start seen after k edges means the wrap happens on edge k+1
    chk("t6_first_wrap_edge", k + 1, 3328);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
